// File: rtl/rr_arbiter16.sv
// rr_arbiter16: round-robin arbiter, 16 requesters onto one channel.
// Bursts up to MAX_BURST words per grant, one idle bubble per handoff.

module mux16 #(
   parameter int N = 32
) (
   input  logic [3:0]      sel,
   input  logic [16*N-1:0] din,
   output logic [N-1:0]    dout
);

   // Plain indexed word select.
   always_comb begin
      dout = din[sel*N +: N];
   end

endmodule

module rr_arbiter16 #(
   parameter int N         = 32,
   parameter int MAX_BURST = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [15:0]     req,
   input  logic [16*N-1:0] data_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    out_data,
   output logic [15:0]     ack,
   output logic [3:0]      gnt_idx,
   output logic            busy
);

   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t        state, state_n;
   logic [3:0]    ptr, ptr_n;
   logic [3:0]    gnt_n;
   logic [BW-1:0] burst_cnt, cnt_n;
   logic [3:0]    pick;
   logic          cur_req;
   logic          xfer;
   logic          last;

   mux16 #(.N(N)) u_mux (
      .sel  (gnt_idx),
      .din  (data_in),
      .dout (out_data)
   );

   // First requester at or after ptr, wrapping modulo 16.
   always_comb begin
      logic       found;
      logic [3:0] idx;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
         idx = ptr + 4'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // Handshake outputs; reset forces them low immediately.
   always_comb begin
      cur_req   = req[gnt_idx];
      busy      = !rst && (state == GRANT);
      out_valid = busy && cur_req;
      xfer      = out_valid && out_ready;
      last      = (burst_cnt == BW'(MAX_BURST - 1));
      ack       = xfer ? (16'd1 << gnt_idx) : 16'd0;
   end

   // Next-state logic for grant, burst count and rotation.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      gnt_n   = gnt_idx;
      cnt_n   = burst_cnt;
      unique case (state)
         IDLE: begin
            if (|req) begin
               gnt_n   = pick;
               cnt_n   = '0;
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (xfer) begin
               cnt_n = burst_cnt + BW'(1);
            end
            if (!cur_req || (xfer && last)) begin
               ptr_n   = gnt_idx + 4'd1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt_idx   <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         gnt_idx   <= gnt_n;
         burst_cnt <= cnt_n;
      end
   end

endmodule
